seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-segment encode path: snoops the multiplexed seven-segment bus (segment lines plus one-hot digit select) and reconstructs per-digit BCD values.
- Used for display self-test and readback: the watch core compares the digits it drives against the digits it recovers.
- Sits beside the display scan driver, on the same clock.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digit positions (hh:mm:ss).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (>=2).
- CNT_W, 3, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deasserted synchronously with clk.
- enable  in  1  when 0, the block samples nothing and holds all captured outputs.
- clear  in  1  synchronous; clears captured values, the frame mask and the valid bits.
- common_anode  in  1  1 = segment bus is active-low; the block inverts it before decode.
- seg_data  in  7  segments a..g, bit6 = a, bit0 = g.
- digit_sel  in  NUM_DIGITS  one-hot active-high digit select; bit i = digit i.
- bcd_out  out  4*NUM_DIGITS  recovered digits; digit i is bcd_out[4i+3:4i].
- blank_out  out  NUM_DIGITS  digit i was last captured as all-off.
- valid_out  out  NUM_DIGITS  digit i has a legal capture since reset or clear.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse or clear.
- err  out  1  one-cycle pulse: a stable pattern was illegal, or digit_sel was multi-hot.
- err_code  out  2  qualified by err: 01 = illegal pattern, 10 = multi-hot select.

Behaviour:
Input normalisation and decode:
- Normalised pattern p = common_anode ? ~seg_data : seg_data.
- Legal decode of p:
  - 1111110 -> 0
  - 0110000 -> 1
  - 1101101 -> 2
  - 1111001 -> 3
  - 0110011 -> 4
  - 1011011 -> 5
  - 0011111 -> 6
  - 1110000 -> 7
  - 1111111 -> 8
  - 1110011 -> 9
  - 0000000 -> blank
  - anything else -> illegal.

Reset (rst_n = 0):
- bcd_out = 0, blank_out = all 1, valid_out = 0, frame_done = 0, err = 0, err_code = 00.
- FSM goes to IDLE; counter, sample registers and frame mask are cleared.

Sampling:
- {digit_sel, p} is registered every cycle while enable = 1.
- A sample is "same" when it equals the previous sample in both fields.

FSM states:
- IDLE: entered when digit_sel is zero or multi-hot.
  - Counter = 0.
  - A multi-hot select pulses err (code 10) once on entry.
  - Go to TRACK when a one-hot select is sampled; counter = 1.
- TRACK:
  - A same sample increments the counter.
  - A differing one-hot sample restarts the count at 1 and stays in TRACK.
  - Zero or multi-hot select goes to IDLE.
  - When the counter reaches STABLE_CYCLES, capture and go to HOLD.
- Capture (in the cycle the counter reaches STABLE_CYCLES):
  - Legal pattern: update bcd_out/blank_out for digit i (blank writes bcd 0, blank 1); set valid_out[i]; set frame-mask bit i.
  - Illegal pattern: pulse err (code 01); clear valid_out[i]; bcd_out[i] unchanged.
- HOLD: no re-capture while samples stay the same.
  - A differing one-hot sample goes to TRACK with counter 1.
  - Zero or multi-hot select goes to IDLE.

Latency:
- With constant inputs first sampled at edge 1, outputs update at edge STABLE_CYCLES+1.

Frame completion:
- When the frame mask becomes all ones, frame_done pulses in the next cycle and the mask clears in that same cycle.
- A capture coincident with that clear sets its bit in the new mask.

Boundary conditions:
- enable = 0: FSM and counter freeze and sample registers hold. Resuming compares the new input against the held sample.
- clear = 1 takes priority over a simultaneous capture; the capture is discarded.
- A select or pattern glitch shorter than STABLE_CYCLES never captures.
- Recapturing an already captured digit overwrites its value; the mask bit stays set.
- rst_n asserted mid-frame resets immediately, independent of clk.

Test Plan:
1. Reset with STABLE_CYCLES = 4, then common_anode = 0, digit_sel = 000001, seg_data = 1101101 held 6 cycles -> bcd_out[3:0] = 2 and valid_out[0] = 1 at edge 5; no further update at edge 6.
2. Scan the six digits with patterns for 1,2,3,4,5,9, each held 5 cycles -> bcd_out = 0x954321 (digit5..digit0) and exactly one frame_done pulse, one cycle after the digit-5 capture.
3. common_anode = 1, seg_data = 0000001 (normalised 1111110) on digit 3 -> digit 3 = 0; then seg_data = 1111111 on digit 3 -> blank_out[3] = 1, bcd 0.
4. Pattern 1010101 held 5 cycles on digit 2 -> single err pulse with err_code 01, valid_out[2] = 0, bcd_out[11:8] unchanged.
5. digit_sel = 000011 -> err pulse with code 10 and no capture. Then 3-cycle stable runs alternating digits 0 and 1 -> no capture.
6. Assert rst_n low mid-frame after 3 captures -> all outputs at reset values without a clk edge. clear pulsed simultaneously with a capture -> valid_out stays 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Seven-segment scan bus as seen by the decoder: the multiplexed segment
// lines and digit select coming in, the recovered digits and status going out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    enable;
    logic                    clear;
    logic                    common_anode;
    logic [6:0]              seg_data;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic [NUM_DIGITS-1:0]   valid_out;
    logic                    frame_done;
    logic                    err;
    logic [1:0]              err_code;

    // Drives the display bus and reads back the recovered digits.
    modport master (
        output enable, clear, common_anode, seg_data, digit_sel,
        input  bcd_out, blank_out, valid_out, frame_done, err, err_code
    );

    // The decoder itself.
    modport slave (
        input  enable, clear, common_anode, seg_data, digit_sel,
        output bcd_out, blank_out, valid_out, frame_done, err, err_code
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed seven-segment bus and rebuilds the BCD value shown on
// each digit. A {select, pattern} sample must stay identical for
// STABLE_CYCLES enabled cycles before it is captured; the capture lands on
// the outputs one cycle after the stability count completes.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave scan
);
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] val;
    } dec_t;

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_MULTI   = 2'b10;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [6:0]              pat_q;
    logic                    cap_req_q, cap_req_d;
    logic                    mh_req_q, mh_req_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;

    logic [6:0] pat_in;
    logic       sel_onehot;
    logic       sel_multi;
    logic       same;
    dec_t       dec;

    function automatic dec_t decode(input logic [6:0] p);
        dec_t d;
        d = '{legal: 1'b1, blank: 1'b0, val: 4'd0};
        case (p)
            7'b1111110: d.val = 4'd0;
            7'b0110000: d.val = 4'd1;
            7'b1101101: d.val = 4'd2;
            7'b1111001: d.val = 4'd3;
            7'b0110011: d.val = 4'd4;
            7'b1011011: d.val = 4'd5;
            7'b0011111: d.val = 4'd6;
            7'b1110000: d.val = 4'd7;
            7'b1111111: d.val = 4'd8;
            7'b1110011: d.val = 4'd9;
            7'b0000000: d.blank = 1'b1;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    assign pat_in     = scan.common_anode ? ~scan.seg_data : scan.seg_data;
    assign sel_onehot = (scan.digit_sel != '0) &&
                        ((scan.digit_sel & (scan.digit_sel - NUM_DIGITS'(1))) == '0);
    assign sel_multi  = (scan.digit_sel != '0) && !sel_onehot;
    assign same       = (scan.digit_sel == sel_q) && (pat_in == pat_q);
    assign dec        = decode(pat_q);

    // Stability FSM: count identical one-hot samples, request one capture per run.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_req_d = 1'b0;
        mh_req_d  = sel_multi && !same;
        case (state_q)
            IDLE: begin
                if (sel_onehot) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            TRACK: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
                        state_d   = HOLD;
                        cap_req_d = 1'b1;
                    end
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
            HOLD: begin
                if (!sel_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sample registers and FSM state; all frozen while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            pat_q     <= '0;
            cap_req_q <= 1'b0;
            mh_req_q  <= 1'b0;
        end else if (scan.enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= scan.digit_sel;
            pat_q     <= pat_in;
            cap_req_q <= cap_req_d;
            mh_req_q  <= mh_req_d;
        end else if (scan.clear) begin
            cap_req_q <= 1'b0;
            mh_req_q  <= 1'b0;
        end
    end

    // Capture stage: write the held sample into its digit, track frame coverage.
    always_comb begin
        bcd_d   = bcd_q;
        blank_d = blank_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        frame_d = 1'b0;
        err_d   = 1'b0;
        code_d  = 2'b00;
        if (scan.clear) begin
            bcd_d   = '0;
            blank_d = '1;
            valid_d = '0;
            mask_d  = '0;
        end else if (scan.enable) begin
            if (&mask_q) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end
            if (cap_req_q) begin
                if (!dec.legal) begin
                    err_d  = 1'b1;
                    code_d = ERR_ILLEGAL;
                end
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        valid_d[i] = dec.legal;
                        if (dec.legal) begin
                            bcd_d[4*i +: 4] = dec.val;
                            blank_d[i]      = dec.blank;
                            mask_d[i]       = 1'b1;
                        end
                    end
                end
            end else if (mh_req_q) begin
                err_d  = 1'b1;
                code_d = ERR_MULTI;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            blank_q <= '1;
            valid_q <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign scan.bcd_out    = bcd_q;
    assign scan.blank_out  = blank_q;
    assign scan.valid_out  = valid_q;
    assign scan.frame_done = frame_q;
    assign scan.err        = err_q;
    assign scan.err_code   = code_q;
endmodule
